// File: rtl/fifo_ex_pkg.sv
// fifo_ex_pkg: width helpers and parameter legality check shared by the fifo_ex files
package fifo_ex_pkg;

    // Pointer width; a depth of 2 still needs one bit.
    function automatic int ptr_w(input int depth);
        return ($clog2(depth) < 1) ? 1 : $clog2(depth);
    endfunction

    // Level width: must be able to hold the value depth itself.
    function automatic int lvl_w(input int depth);
        return $clog2(depth + 1);
    endfunction

    // Legal configurations: at least two entries and ordered watermarks within the depth.
    function automatic bit params_ok(input int depth, input int ae, input int af);
        return (depth >= 2) && (ae < af) && (af <= depth);
    endfunction

endpackage

// File: rtl/fifo_ex_ptr.sv
// fifo_ex_ptr: wrapping pointer counter for any depth, with clear and clear-to-one
module fifo_ex_ptr
    import fifo_ex_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clr,
    input  logic                      load1,
    input  logic                      inc,
    output logic [ptr_w(DEPTH)-1:0]   ptr
);
    localparam int PW = ptr_w(DEPTH);

    logic [PW-1:0] ptr_q, ptr_d;

    // Next pointer: clear (optionally to 1 for a flush that also writes), else advance and wrap at DEPTH-1.
    always_comb
        ptr_d = clr ? (load1 ? PW'(1) : '0)
              : !inc ? ptr_q
              : (ptr_q == PW'(DEPTH - 1)) ? '0 : ptr_q + PW'(1);

    // Pointer register.
    always_ff @(posedge clk)
        ptr_q <= rst ? '0 : ptr_d;

    assign ptr = ptr_q;
endmodule

// File: rtl/fifo_ex.sv
// fifo_ex: synchronous FIFO with arbitrary depth, level/watermark flags and FWFT option; sticky errors with FIFO_EX_ERR_EN
module fifo_ex
    import fifo_ex_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int FWFT       = 0,
    parameter int AF_LEVEL   = FIFO_DEPTH - 1,
    parameter int AE_LEVEL   = 1
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          write,
    input  logic [DATA_WIDTH-1:0]         data_in,
    input  logic                          read,
    output logic [DATA_WIDTH-1:0]         data_out,
    input  logic                          flush,
    output logic                          empty,
    output logic                          full,
    output logic                          almost_empty,
    output logic                          almost_full,
    output logic [lvl_w(FIFO_DEPTH)-1:0]  level,
    output logic                          overflow,
    output logic                          underflow
);
    localparam int PW = ptr_w(FIFO_DEPTH);
    localparam int LW = lvl_w(FIFO_DEPTH);

    if (!params_ok(FIFO_DEPTH, AE_LEVEL, AF_LEVEL) || FWFT < 0 || FWFT > 1 || DATA_WIDTH < 1) begin : g_bad_params
        $error("fifo_ex: illegal parameter combination");
    end

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]         wptr, rptr, mem_idx;
    logic [LW-1:0]         level_q, level_d;
    logic                  rd_ok, wr_ok, bypass, wr_push, rd_pop, mem_we;

    // Flags come only from the registered level, never from this cycle's requests.
    assign empty        = (level_q == '0);
    assign full         = (level_q == LW'(FIFO_DEPTH));
    assign almost_empty = (level_q <= LW'(AE_LEVEL));
    assign almost_full  = (level_q >= LW'(AF_LEVEL));
    assign level        = level_q;

    // Acceptance: registered-read mode may serve a read on empty from the incoming word;
    // a write at full is accepted only when a read frees the slot in the same cycle.
    always_comb begin
        rd_ok   = read && (!empty || (FWFT == 0 && write));
        wr_ok   = write && (!full || rd_ok);
        bypass  = (FWFT == 0) && empty && read && write;
        wr_push = !flush && wr_ok && !bypass;
        rd_pop  = !flush && rd_ok && !bypass;
        mem_we  = !rst && (flush ? write : wr_push);
        mem_idx = flush ? '0 : wptr;
    end

    fifo_ex_ptr #(.DEPTH(FIFO_DEPTH)) u_wptr (
        .clk   (clk),
        .rst   (rst),
        .clr   (flush),
        .load1 (write),
        .inc   (wr_push),
        .ptr   (wptr)
    );

    fifo_ex_ptr #(.DEPTH(FIFO_DEPTH)) u_rptr (
        .clk   (clk),
        .rst   (rst),
        .clr   (flush),
        .load1 (1'b0),
        .inc   (rd_pop),
        .ptr   (rptr)
    );

    // Storage write; contents survive reset and flush.
    always_ff @(posedge clk)
        if (mem_we) mem_q[mem_idx] <= data_in;

    // Next level: flush restarts at 0 or 1, otherwise net of push and pop.
    always_comb
        level_d = flush ? LW'(write)
                : (wr_push && !rd_pop) ? level_q + LW'(1)
                : (rd_pop && !wr_push) ? level_q - LW'(1)
                : level_q;

    // Level register.
    always_ff @(posedge clk)
        level_q <= rst ? '0 : level_d;

    if (FWFT == 0) begin : g_reg_read
        logic [DATA_WIDTH-1:0] dout_q, dout_d;

        // Registered output loads the head, or the bypassed write word, only on an accepted read.
        always_comb
            dout_d = (flush || !rd_ok) ? dout_q : bypass ? data_in : mem_q[rptr];

        // Output register.
        always_ff @(posedge clk)
            dout_q <= rst ? '0 : dout_d;

        assign data_out = dout_q;
    end else begin : g_fwft_read
        assign data_out = empty ? '0 : mem_q[rptr];
    end

`ifdef FIFO_EX_ERR_EN
    logic ovf_q, ovf_d, unf_q, unf_d;

    // Sticky error capture of refused requests; flush clears and ignores the same-cycle read.
    always_comb begin
        ovf_d = flush ? 1'b0 : (ovf_q || (write && !wr_ok));
        unf_d = flush ? 1'b0 : (unf_q || (read && !rd_ok));
    end

    // Error flag registers.
    always_ff @(posedge clk) begin
        ovf_q <= rst ? 1'b0 : ovf_d;
        unf_q <= rst ? 1'b0 : unf_d;
    end

    assign overflow  = ovf_q;
    assign underflow = unf_q;
`else
    assign overflow  = 1'b0;
    assign underflow = 1'b0;
`endif
endmodule
